// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared encodings for the RV32I execute stage: ALU operations,
//               forwarding selects, branch funct3 codes and operand-B selects.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // ALU operation codes (ALUControlE)
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    // Forwarding selects from the hazard unit; 2'b11 falls back to the register value
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Branch condition codes (Funct3E); 010/011 have no branch meaning
    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    // Operand-B selects (ALUSrcBE)
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Purely combinational RV32I integer ALU. Arithmetic wraps,
//               shift amount is B[4:0], undefined op codes return zero.
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [3:0]      ALUControl,
    output logic [XLEN-1:0] Result
);

    logic [4:0] w_shamt;
    assign w_shamt = B[4:0];

    // Select the operation result; unknown codes yield zero
    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD:   Result = A + B;
            ALU_SUB:   Result = A - B;
            ALU_AND:   Result = A & B;
            ALU_OR:    Result = A | B;
            ALU_XOR:   Result = A ^ B;
            ALU_SLT:   Result = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU:  Result = {{(XLEN-1){1'b0}}, (A < B)};
            ALU_SLL:   Result = A << w_shamt;
            ALU_SRL:   Result = A >> w_shamt;
            ALU_SRA:   Result = $unsigned($signed(A) >>> w_shamt);
            ALU_PASSB: Result = B;
            default:   Result = '0;
        endcase
    end

endmodule : alu
`default_nettype wire

// File: rtl/execute_cycle.sv
`default_nettype none
// ============================================================================
// Module      : execute_cycle
// Description : RV32I execute stage. Forwards operands, runs the ALU,
//               resolves branches/jumps (same-cycle redirect to fetch) and
//               holds the EX/MEM pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_cycle
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            BranchE,
    input  logic            JumpE,
    input  logic            ALUSrcAE,
    input  logic [1:0]      ALUSrcBE,
    input  logic [1:0]      ResultSrcE,
    input  logic [3:0]      ALUControlE,
    input  logic [2:0]      Funct3E,
    input  logic            TargetSrcE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RDE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [4:0]      RDM
);

    localparam logic [XLEN-1:0] C_FOUR = XLEN'(4);

    logic [XLEN-1:0] w_src_af;
    logic [XLEN-1:0] w_write_data_e;
    logic [XLEN-1:0] w_src_a;
    logic [XLEN-1:0] w_src_b;
    logic [XLEN-1:0] w_alu_result_e;
    logic            w_branch_cond;

    logic            reg_write_d,   reg_write_q;
    logic            mem_write_d,   mem_write_q;
    logic [1:0]      result_src_d,  result_src_q;
    logic [XLEN-1:0] alu_result_d,  alu_result_q;
    logic [XLEN-1:0] write_data_d,  write_data_q;
    logic [XLEN-1:0] pc_plus4_d,    pc_plus4_q;
    logic [4:0]      rd_d,          rd_q;

    // Forwarding muxes; the M-stage source is this stage's own registered result
    always_comb begin
        case (ForwardAE)
            FWD_WB:  w_src_af = ResultW;
            FWD_MEM: w_src_af = alu_result_q;
            default: w_src_af = RD1E;
        endcase
        case (ForwardBE)
            FWD_WB:  w_write_data_e = ResultW;
            FWD_MEM: w_write_data_e = alu_result_q;
            default: w_write_data_e = RD2E;
        endcase
    end

    // ALU operand selection (PC for AUIPC, constant 4 for link computations)
    always_comb begin
        w_src_a = ALUSrcAE ? PCE : w_src_af;
        case (ALUSrcBE)
            SRCB_REG:  w_src_b = w_write_data_e;
            SRCB_FOUR: w_src_b = C_FOUR;
            default:   w_src_b = ImmExtE;
        endcase
    end

    alu #(.XLEN(XLEN)) u_alu (
        .A          (w_src_a),
        .B          (w_src_b),
        .ALUControl (ALUControlE),
        .Result     (w_alu_result_e)
    );

    // Branch comparison on the forwarded register values, independent of the ALU
    always_comb begin
        case (Funct3E)
            BR_EQ:   w_branch_cond = (w_src_af == w_write_data_e);
            BR_NE:   w_branch_cond = (w_src_af != w_write_data_e);
            BR_LT:   w_branch_cond = ($signed(w_src_af) <  $signed(w_write_data_e));
            BR_GE:   w_branch_cond = ($signed(w_src_af) >= $signed(w_write_data_e));
            BR_LTU:  w_branch_cond = (w_src_af <  w_write_data_e);
            BR_GEU:  w_branch_cond = (w_src_af >= w_write_data_e);
            default: w_branch_cond = 1'b0;
        endcase
    end

    // Same-cycle redirect; JALR target has bit0 forced low, no alignment trap
    assign PCSrcE    = JumpE | (BranchE & w_branch_cond);
    assign PCTargetE = TargetSrcE ? {w_alu_result_e[XLEN-1:1], 1'b0} : (PCE + ImmExtE);

    // Next-state values for the EX/MEM register (loaded unconditionally)
    always_comb begin
        reg_write_d  = RegWriteE;
        mem_write_d  = MemWriteE;
        result_src_d = ResultSrcE;
        alu_result_d = w_alu_result_e;
        write_data_d = w_write_data_e;
        pc_plus4_d   = PCPlus4E;
        rd_d         = RDE;
    end

    // EX/MEM pipeline register with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
            rd_q         <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pc_plus4_q   <= pc_plus4_d;
            rd_q         <= rd_d;
        end
    end

    assign RegWriteM  = reg_write_q;
    assign MemWriteM  = mem_write_q;
    assign ResultSrcM = result_src_q;
    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign PCPlus4M   = pc_plus4_q;
    assign RDM        = rd_q;

endmodule : execute_cycle
`default_nettype wire

// File: tb/tb_execute_cycle.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_cycle
// Description : Self-checking bench for execute_cycle: directed cases,
//               randomized instructions against a reference model, and an
//               asynchronous reset in the middle of a stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcAE, TargetSrcE;
    logic [1:0]  ALUSrcBE, ResultSrcE, ForwardAE, ForwardBE;
    logic [3:0]  ALUControlE;
    logic [2:0]  Funct3E;
    logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW;
    logic [4:0]  RDE;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RDM;

    int checks   = 0;
    int failures = 0;

    // Reference model state: what the M stage should currently hold
    logic [31:0] m_alum;

    always #5 clk = ~clk;

    execute_cycle #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
        .JumpE(JumpE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .Funct3E(Funct3E),
        .TargetSrcE(TargetSrcE), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
        .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E), .RDE(RDE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .RDM(RDM)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] rd,
                                          input logic [31:0] wb, input logic [31:0] mem);
        if (sel == 2'd1)      return wb;
        else if (sel == 2'd2) return mem;
        else                  return rd;
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int unsigned sh;
        longint sa, sb;
        sh = b % 32;
        sa = a[31] ? longint'(a) - 64'sd4294967296 : longint'(a);
        sb = b[31] ? longint'(b) - 64'sd4294967296 : longint'(b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return a << sh;
            4'd8:  return a >> sh;
            4'd9:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_cond(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
        longint sa, sb;
        sa = a[31] ? longint'(a) - 64'sd4294967296 : longint'(a);
        sb = b[31] ? longint'(b) - 64'sd4294967296 : longint'(b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic clear_in();
        RegWriteE = 0; MemWriteE = 0; BranchE = 0; JumpE = 0; ALUSrcAE = 0;
        TargetSrcE = 0; ALUSrcBE = 0; ResultSrcE = 0; ForwardAE = 0; ForwardBE = 0;
        ALUControlE = 0; Funct3E = 0; RD1E = 0; RD2E = 0; PCE = 0; ImmExtE = 0;
        PCPlus4E = 0; ResultW = 0; RDE = 0;
    endtask

    // Check the redirect now, clock once, check the M stage against the model
    task automatic step(input string tag);
        logic [31:0] sa, wd, a, b, res, tgt;
        logic        take;
        sa  = m_fwd(ForwardAE, RD1E, ResultW, m_alum);
        wd  = m_fwd(ForwardBE, RD2E, ResultW, m_alum);
        a   = ALUSrcAE ? PCE : sa;
        b   = (ALUSrcBE == 2'd0) ? wd : (ALUSrcBE == 2'd2) ? 32'd4 : ImmExtE;
        res = m_alu(ALUControlE, a, b);
        take = JumpE | (BranchE & m_cond(Funct3E, sa, wd));
        tgt = TargetSrcE ? (res & 32'hFFFF_FFFE) : PCE + ImmExtE;
        #1;
        chk({tag, ".pcsrc"}, {31'd0, PCSrcE}, {31'd0, take});
        chk({tag, ".target"}, PCTargetE, tgt);
        @(posedge clk);
        #1;
        chk({tag, ".regwr"}, {31'd0, RegWriteM}, {31'd0, RegWriteE});
        chk({tag, ".memwr"}, {31'd0, MemWriteM}, {31'd0, MemWriteE});
        chk({tag, ".rsrc"}, {30'd0, ResultSrcM}, {30'd0, ResultSrcE});
        chk({tag, ".alu"}, ALUResultM, res);
        chk({tag, ".wdata"}, WriteDataM, wd);
        chk({tag, ".pc4"}, PCPlus4M, PCPlus4E);
        chk({tag, ".rd"}, {27'd0, RDM}, {27'd0, RDE});
        m_alum = res;
    endtask

    task automatic chk_m_zero(input string tag);
        chk({tag, ".regwr"}, {31'd0, RegWriteM}, 32'd0);
        chk({tag, ".memwr"}, {31'd0, MemWriteM}, 32'd0);
        chk({tag, ".rsrc"}, {30'd0, ResultSrcM}, 32'd0);
        chk({tag, ".alu"}, ALUResultM, 32'd0);
        chk({tag, ".wdata"}, WriteDataM, 32'd0);
        chk({tag, ".pc4"}, PCPlus4M, 32'd0);
        chk({tag, ".rd"}, {27'd0, RDM}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        m_alum = 32'd0;
        #12;
        chk_m_zero("reset");
        chk("reset.pcsrc", {31'd0, PCSrcE}, 32'd0);
        chk("reset.target", PCTargetE, 32'd0);
        rst = 1'b0;

        // Prime ALUResultM = 7, then ADD forwarding from M: 5 -> replaced by 7, +3
        clear_in(); RD1E = 7; ALUSrcBE = 2'b01; step("prime7");
        clear_in(); RD1E = 5; ForwardAE = 2'b10; ImmExtE = 3; ALUSrcBE = 2'b01;
        RegWriteE = 1; RDE = 5'd9; step("add_fwd_m");
        chk("add_fwd_m.const", ALUResultM, 32'd10);

        // BEQ taken / not taken
        clear_in(); BranchE = 1; PCE = 32'h100; ImmExtE = 32'h20; RD1E = 9; RD2E = 9;
        ALUControlE = 4'b0001; #1;
        chk("beq_t.pcsrc", {31'd0, PCSrcE}, 32'd1);
        chk("beq_t.target", PCTargetE, 32'h120);
        step("beq_t");
        clear_in(); BranchE = 1; PCE = 32'h100; ImmExtE = 32'h20; RD1E = 9; RD2E = 8;
        #1; chk("beq_nt.pcsrc", {31'd0, PCSrcE}, 32'd0);
        step("beq_nt");

        // BLT vs BLTU on -1 and 1
        clear_in(); BranchE = 1; RD1E = 32'hFFFF_FFFF; RD2E = 1; Funct3E = 3'b100;
        #1; chk("blt.pcsrc", {31'd0, PCSrcE}, 32'd1);
        step("blt");
        clear_in(); BranchE = 1; RD1E = 32'hFFFF_FFFF; RD2E = 1; Funct3E = 3'b110;
        #1; chk("bltu.pcsrc", {31'd0, PCSrcE}, 32'd0);
        step("bltu");

        // JALR with misaligned target: bit0 cleared, bit1 kept
        clear_in(); JumpE = 1; TargetSrcE = 1; RD1E = 32'h203; ALUSrcBE = 2'b01;
        PCPlus4E = 32'h0000_0444; RegWriteE = 1; RDE = 5'd1;
        #1; chk("jalr.target", PCTargetE, 32'h202);
        step("jalr");
        chk("jalr.pc4.const", PCPlus4M, 32'h444);

        // Shifts, LUI and other boundaries
        clear_in(); RD1E = 32'h8000_0000; ImmExtE = 4; ALUSrcBE = 2'b01; ALUControlE = 4'b1001;
        step("sra4");  chk("sra4.const", ALUResultM, 32'hF800_0000);
        clear_in(); RD1E = 32'h8000_0000; ImmExtE = 4; ALUSrcBE = 2'b01; ALUControlE = 4'b1000;
        step("srl4");  chk("srl4.const", ALUResultM, 32'h0800_0000);
        clear_in(); ImmExtE = 32'h1234_5000; ALUSrcBE = 2'b01; ALUControlE = 4'b1010;
        step("lui");   chk("lui.const", ALUResultM, 32'h1234_5000);
        clear_in(); RD1E = 0; ImmExtE = 1; ALUSrcBE = 2'b01; ALUControlE = 4'b0001;
        step("sub0");  chk("sub0.const", ALUResultM, 32'hFFFF_FFFF);
        clear_in(); RD1E = 32'h8000_0000; ImmExtE = 31; ALUSrcBE = 2'b01; ALUControlE = 4'b1001;
        step("sra31"); chk("sra31.const", ALUResultM, 32'hFFFF_FFFF);
        clear_in(); RD1E = 32'h8000_0000; RD2E = 1; ALUControlE = 4'b0101;
        step("slt");   chk("slt.const", ALUResultM, 32'd1);
        clear_in(); RD1E = 32'h8000_0000; RD2E = 1; ALUControlE = 4'b0110;
        step("sltu");  chk("sltu.const", ALUResultM, 32'd0);
        clear_in(); RD1E = 32'h11; RD2E = 32'h22; ResultW = 32'h99; ForwardAE = 2'b11;
        ForwardBE = 2'b11;
        step("fwd11"); chk("fwd11.const", ALUResultM, 32'h33);
        chk("fwd11.wd.const", WriteDataM, 32'h22);

        // Randomized instructions against the model
        for (int i = 0; i < 300; i++) begin
            RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); BranchE = 1'($urandom);
            JumpE = 1'($urandom); ALUSrcAE = 1'($urandom); TargetSrcE = 1'($urandom);
            ALUSrcBE = 2'($urandom); ResultSrcE = 2'($urandom);
            ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
            ALUControlE = 4'($urandom_range(0, 15)); Funct3E = 3'($urandom);
            RD1E = $urandom; PCE = $urandom; ImmExtE = $urandom; PCPlus4E = $urandom;
            ResultW = $urandom; RDE = 5'($urandom);
            RD2E = ($urandom_range(0, 3) == 0) ? RD1E : $urandom;
            step("rand");
        end

        // Asynchronous reset between clock edges
        clear_in(); RegWriteE = 1; MemWriteE = 1; ResultSrcE = 2'b10; RD1E = 32'h55;
        RD2E = 32'h66; PCPlus4E = 32'h88; RDE = 5'd7;
        step("pre_rst");
        #2;
        rst = 1'b1;
        #1;
        chk_m_zero("async_rst");
        @(posedge clk);
        #1;
        chk_m_zero("rst_held");
        @(negedge clk);
        rst = 1'b0;
        m_alum = 32'd0;
        clear_in(); RegWriteE = 1; ResultSrcE = 2'b01; RD1E = 32'hA0; ImmExtE = 32'h0B;
        ALUSrcBE = 2'b01; PCPlus4E = 32'h1004; RDE = 5'd3; RD2E = 32'hCAFE;
        step("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_execute_cycle
`default_nettype wire
